// File: rtl/bus_interconnect_if.sv
// Bus-side signal bundle for bus_interconnect: per-port transfer requests with
// destinations in, completion pulse and per-port delivery pulses out.
interface bus_interconnect_if #(
  parameter int NUM_PROC = 4
);
  localparam int DW = $clog2(NUM_PROC) + 1;

  logic [NUM_PROC-1:0]         request;
  logic [NUM_PROC-1:0][DW-1:0] request_dest;
  logic                        processed_request;
  logic [NUM_PROC-1:0]         request_avail;

  modport master (
    output request,
    output request_dest,
    input  processed_request,
    input  request_avail
  );

  modport slave (
    input  request,
    input  request_dest,
    output processed_request,
    output request_avail
  );
endinterface

// File: rtl/bus_interconnect.sv
// Shared-bus interconnect: latches per-port requests, round-robin arbitrates them onto one
// bus with a fixed latency, then pulses delivery. Optional macro BUS_BROADCAST_EN enables broadcast.
module bus_interconnect #(
  parameter int NUM_PROC    = 4,
  parameter int BUS_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_l,
  bus_interconnect_if.slave bus
);
  localparam int IW = $clog2(NUM_PROC);
  localparam int DW = IW + 1;
  localparam int CW = (BUS_LATENCY > 1) ? $clog2(BUS_LATENCY) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state_reg;
  logic [CW-1:0]       count_reg;
  logic [IW-1:0]       last_grant_reg;
  logic [DW-1:0]       dst_reg;
`ifdef BUS_BROADCAST_EN
  logic [IW-1:0]       src_reg;
`endif
  logic                processed_reg;
  logic [NUM_PROC-1:0] avail_reg;

  logic                pending_reg    [NUM_PROC];
  logic [DW-1:0]       dest_store_reg [NUM_PROC];

  logic                grant_found;
  logic [IW-1:0]       grant_idx;
  logic [NUM_PROC-1:0] grant_mask;
  logic [NUM_PROC-1:0] deliver_mask;
  int                  cand;

  // Scan from the farthest offset down so the nearest pending port after last_grant wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = NUM_PROC; off >= 1; off--) begin
      cand = (int'(last_grant_reg) + off) % NUM_PROC;
      if (pending_reg[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
    grant_mask = (state_reg == IDLE && grant_found) ? (NUM_PROC'(1) << grant_idx) : '0;
  end

  always_comb begin
    if (int'(dst_reg) < NUM_PROC) begin
      deliver_mask = NUM_PROC'(1) << dst_reg[IW-1:0];
    end else begin
`ifdef BUS_BROADCAST_EN
      deliver_mask = ~(NUM_PROC'(1) << src_reg);
`else
      deliver_mask = '0;
`endif
    end
  end

  // A request on the same edge as its port's grant re-arms the slot (set beats clear).
  generate
    for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_pending
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          pending_reg[gi]    <= 1'b0;
          dest_store_reg[gi] <= '0;
        end else if (bus.request[gi] && (!pending_reg[gi] || grant_mask[gi])) begin
          pending_reg[gi]    <= 1'b1;
          dest_store_reg[gi] <= bus.request_dest[gi];
        end else if (grant_mask[gi]) begin
          pending_reg[gi]    <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      last_grant_reg <= IW'(NUM_PROC - 1);
      dst_reg        <= '0;
`ifdef BUS_BROADCAST_EN
      src_reg        <= '0;
`endif
      processed_reg  <= 1'b0;
      avail_reg      <= '0;
    end else begin
      processed_reg <= 1'b0;
      avail_reg     <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            last_grant_reg <= grant_idx;
            dst_reg        <= dest_store_reg[grant_idx];
`ifdef BUS_BROADCAST_EN
            src_reg        <= grant_idx;
`endif
            count_reg      <= CW'(BUS_LATENCY - 1);
            state_reg      <= XFER;
          end
        end
        XFER: begin
          if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
          end else begin
            processed_reg <= 1'b1;
            avail_reg     <= deliver_mask;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.processed_request = processed_reg;
  assign bus.request_avail     = avail_reg;
endmodule

// File: tb/tb_bus_interconnect.sv
// Bench for bus_interconnect: directed scenarios plus random traffic, every cycle compared
// against a timeline-based reference model of arbitration and delivery.
module tb_bus_interconnect;
  localparam int NP  = 4;
  localparam int LAT = 2;
  localparam int DW  = $clog2(NP) + 1;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  bus_interconnect_if #(.NUM_PROC(NP)) bus ();

  bus_interconnect #(.NUM_PROC(NP), .BUS_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending slots, time remaining until the in-flight transfer lands.
  bit            m_pend [NP];
  int            m_dest [NP];
  int            m_last, m_busy, m_src, m_dst;
  bit            exp_proc;
  logic [NP-1:0] exp_avail;
  logic [NP-1:0] hist_avail [$];
  bit            hist_proc  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_pend[i] = 1'b0;
      m_dest[i] = 0;
    end
    m_last = NP - 1;
    m_busy = 0;
    m_src  = 0;
    m_dst  = 0;
    exp_proc  = 1'b0;
    exp_avail = '0;
  endtask

  task automatic model_step();
    int g;
    logic [NP-1:0] all_ports;
    all_ports = '1;
    g = -1;
    exp_proc  = 1'b0;
    exp_avail = '0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        exp_proc = 1'b1;
        if (m_dst < NP) exp_avail = NP'(1) << m_dst;
        else begin
`ifdef BUS_BROADCAST_EN
          exp_avail = all_ports & ~(NP'(1) << m_src);
`else
          exp_avail = '0;
`endif
        end
      end
    end else begin
      for (int k = 1; k <= NP; k++) begin
        if (g < 0 && m_pend[(m_last + k) % NP]) g = (m_last + k) % NP;
      end
    end
    if (g >= 0) begin
      m_last = g;
      m_src  = g;
      m_dst  = m_dest[g];
      m_busy = LAT;
    end
    for (int i = 0; i < NP; i++) begin
      if (bus.request[i] && (!m_pend[i] || g == i)) begin
        m_pend[i] = 1'b1;
        m_dest[i] = int'(bus.request_dest[i]);
      end else if (g == i) begin
        m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    $display("t=%0t req=%b proc=%b avail=%b", $time, bus.request, bus.processed_request, bus.request_avail);
    check("proc", 32'(bus.processed_request), 32'(exp_proc));
    check("avail", 32'(bus.request_avail), 32'(exp_avail));
    hist_avail.push_back(bus.request_avail);
    hist_proc.push_back(bus.processed_request);
  endtask

  task automatic do_reset();
    bus.request      = '0;
    bus.request_dest = '0;
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_proc", 32'(bus.processed_request), 32'd0);
    check("rst_avail", 32'(bus.request_avail), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    model_reset();
    hist_avail.delete();
    hist_proc.delete();
  endtask

  task automatic set_req(input int port, input int dest);
    bus.request[port]      = 1'b1;
    bus.request_dest[port] = DW'(dest);
  endtask

  function automatic int proc_count();
    int n = 0;
    foreach (hist_proc[i]) n += int'(hist_proc[i]);
    return n;
  endfunction

  function automatic int avail_or();
    logic [NP-1:0] acc = '0;
    foreach (hist_avail[i]) acc |= hist_avail[i];
    return int'(acc);
  endfunction

  initial begin
    bus.request      = '0;
    bus.request_dest = '0;
    model_reset();

    // Idle after reset
    do_reset();
    repeat (10) tick();
    check("idle_proc", 32'(proc_count()), 32'd0);
    check("idle_avail", 32'(avail_or()), 32'd0);

    // Single unicast: port 0 -> 2 at edge 1, delivered after edge 4
    do_reset();
    set_req(0, 2);
    tick();
    bus.request = '0;
    repeat (6) tick();
    check("uni_avail_e4", 32'(hist_avail[3]), 32'h4);
    check("uni_proc_e4", 32'(hist_proc[3]), 32'd1);
    check("uni_count", 32'(proc_count()), 32'd1);

    // Round robin from reset: port 1 first, port 3 three cycles later
    do_reset();
    set_req(1, 0);
    set_req(3, 1);
    tick();
    bus.request = '0;
    repeat (8) tick();
    check("rr_first", 32'(hist_avail[3]), 32'h1);
    check("rr_second", 32'(hist_avail[6]), 32'h2);
    check("rr_count", 32'(proc_count()), 32'd2);

    // Re-request while pending is ignored (port 0 keeps the bus busy)
    do_reset();
    set_req(0, 1);
    set_req(2, 3);
    tick();
    bus.request = '0;
    set_req(2, 0);
    tick();
    bus.request = '0;
    repeat (10) tick();
    check("ign_port0", 32'(hist_avail[3]), 32'h2);
    check("ign_port2", 32'(hist_avail[6]), 32'h8);
    check("ign_count", 32'(proc_count()), 32'd2);

    // Broadcast-class destination from port 1
    do_reset();
    set_req(1, 4);
    tick();
    bus.request = '0;
    repeat (6) tick();
    check("bc_proc", 32'(hist_proc[3]), 32'd1);
`ifdef BUS_BROADCAST_EN
    check("bc_avail", 32'(hist_avail[3]), 32'hD);
`else
    check("bc_avail", 32'(hist_avail[3]), 32'h0);
`endif

    // Reset during XFER discards the transfer
    do_reset();
    set_req(0, 1);
    tick();
    bus.request = '0;
    repeat (2) tick();
    rst_l = 1'b0;
    #1;
    check("xrst_proc", 32'(bus.processed_request), 32'd0);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    hist_proc.delete();
    hist_avail.delete();
    repeat (8) tick();
    check("xrst_none", 32'(proc_count()), 32'd0);

    // Asynchronous reset clears an active delivery pulse immediately
    do_reset();
    set_req(3, 0);
    tick();
    bus.request = '0;
    repeat (3) tick();
    check("arst_pre", 32'(bus.processed_request), 32'd1);
    rst_l = 1'b0;
    #1;
    check("arst_proc", 32'(bus.processed_request), 32'd0);
    check("arst_avail", 32'(bus.request_avail), 32'd0);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;

    // Random traffic against the model
    do_reset();
    repeat (400) begin
      for (int p = 0; p < NP; p++) begin
        bus.request[p]      = ($urandom_range(0, 3) == 0);
        bus.request_dest[p] = DW'($urandom_range(0, (1 << DW) - 1));
      end
      tick();
    end
    bus.request = '0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
